// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pins and the byte-level transmit/receive handshake of
// spi_slave into one interface.
//   SCLK, CS, MOSI : SPI pins from the link master (asynchronous to CLK)
//   MISO           : serial data back to the link master
//   tx_data/tx_valid/tx_ready : byte-wide transmit holding register handshake
//   rx_data/rx_valid          : received byte and its one-cycle strobe
//   underrun, frame_err       : one-cycle event pulses
//   busy                      : frame in progress
// Modports: slave (the responder block) and master (whoever drives it).
// ---------------------------------------------------------------------------
interface spi_slave_if;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       underrun;
  logic       frame_err;
  logic       busy;

  modport slave (
    input  SCLK, CS, MOSI, tx_data, tx_valid,
    output MISO, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
  );

  modport master (
    output SCLK, CS, MOSI, tx_data, tx_valid,
    input  MISO, tx_ready, rx_data, rx_valid, underrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI responder for 8-bit MSB-first frames. All SPI pins are oversampled on
// CLK through two synchronizer flops; SCLK and CS get a third flop for edge
// detection, so every pin edge acts on the 3rd CLK rising edge after it.
// Received bytes appear on rx_data with a one-cycle rx_valid pulse. Transmit
// bytes are accepted into a one-entry holding register (valid/ready) and
// moved into the output shifter at CS fall and at each byte boundary.
// Ports:
//   CLK   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : spi_slave_if.slave (SPI pins, tx/rx handshake, status pulses)
// Parameters:
//   MODE  : {CPOL, CPHA}
//   WIDTH : frame width (8 only)
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter logic [1:0] MODE  = 2'd3,
  parameter int         WIDTH = 8
) (
  input  logic        CLK,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Pin vector order: {SCLK, CS, MOSI}; idle values used at reset.
  localparam logic [2:0] PIN_IDLE = {CPOL, 1'b1, 1'b0};

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [2:0] pin_async;
  logic [2:0] sync1_reg, sync2_reg;
  logic [1:0] edge3_reg;  // third stage for {SCLK, CS} only

  assign pin_async = {bus.SCLK, bus.CS, bus.MOSI};

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_reg <= PIN_IDLE;
      sync2_reg <= PIN_IDLE;
      edge3_reg <= PIN_IDLE[2:1];
    end else begin
      sync1_reg <= pin_async;
      sync2_reg <= sync1_reg;
      edge3_reg <= sync2_reg[2:1];
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_rise   =  sync2_reg[2] & ~edge3_reg[1];
  assign sclk_fall   = ~sync2_reg[2] &  edge3_reg[1];
  assign cs_rise     =  sync2_reg[1] & ~edge3_reg[0];
  assign cs_fall     = ~sync2_reg[1] &  edge3_reg[0];
  // MOSI is taken from the same stage the SCLK edge is detected from, so the
  // data bit and the clock edge stay aligned through the synchronizers.
  assign mosi_sync   =  sync2_reg[0];

  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shifter_reg, shifter_next;
  logic [WIDTH-1:0]  rx_shift_reg, rx_shift_next;
  logic [WIDTH-1:0]  rx_data_reg, rx_data_next;
  logic [WIDTH-1:0]  hold_data_reg, hold_data_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              hold_full_reg, hold_full_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              underrun_reg, underrun_next;
  logic              frame_err_reg, frame_err_next;
  logic              miso_reg, miso_next;
  logic              skip_shift_reg, skip_shift_next;
  logic              load, accept;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg      <= IDLE;
      shifter_reg    <= '0;
      rx_shift_reg   <= '0;
      rx_data_reg    <= '0;
      hold_data_reg  <= '0;
      cnt_reg        <= '0;
      hold_full_reg  <= 1'b0;
      rx_valid_reg   <= 1'b0;
      underrun_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      miso_reg       <= 1'b0;
      skip_shift_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shifter_reg    <= shifter_next;
      rx_shift_reg   <= rx_shift_next;
      rx_data_reg    <= rx_data_next;
      hold_data_reg  <= hold_data_next;
      cnt_reg        <= cnt_next;
      hold_full_reg  <= hold_full_next;
      rx_valid_reg   <= rx_valid_next;
      underrun_reg   <= underrun_next;
      frame_err_reg  <= frame_err_next;
      miso_reg       <= miso_next;
      skip_shift_reg <= skip_shift_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shifter_next    = shifter_reg;
    rx_shift_next   = rx_shift_reg;
    rx_data_next    = rx_data_reg;
    hold_data_next  = hold_data_reg;
    cnt_next        = cnt_reg;
    hold_full_next  = hold_full_reg;
    rx_valid_next   = 1'b0;
    underrun_next   = 1'b0;
    frame_err_next  = 1'b0;
    miso_next       = miso_reg;
    skip_shift_next = skip_shift_reg;
    load            = 1'b0;
    accept          = bus.tx_valid & ~hold_full_reg;

    case (state_reg)
      IDLE: begin
        miso_next = 1'b0;
        if (cs_fall) begin
          state_next      = ACTIVE;
          load            = 1'b1;
          cnt_next        = '0;
          skip_shift_next = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          miso_next  = 1'b0;
          cnt_next   = '0;
          if (cnt_reg != '0) begin
            frame_err_next = 1'b1;
          end
        end else begin
          if (shift_edge) begin
            if (skip_shift_reg) begin
              skip_shift_next = 1'b0;
            end else begin
              miso_next    = shifter_reg[WIDTH-1];
              shifter_next = {shifter_reg[WIDTH-2:0], 1'b0};
            end
          end
          if (sample_edge) begin
            rx_shift_next = {rx_shift_reg[WIDTH-2:0], mosi_sync};
            cnt_next      = cnt_reg + CW'(1);
            if (cnt_reg == CNT_LAST) begin
              rx_data_next  = {rx_shift_reg[WIDTH-2:0], mosi_sync};
              rx_valid_next = 1'b1;
              load          = 1'b1;
              // With CPHA=0 the byte ends on a leading edge and the freshly
              // loaded MSB must survive the trailing edge that follows, so
              // that one shift is swallowed.
              skip_shift_next = ~CPHA;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shifter_next  = hold_full_reg ? hold_data_reg : '0;
      underrun_next = ~hold_full_reg;
    end

    // A load empties the holding register; a same-cycle accept refills it.
    hold_full_next = (hold_full_reg & ~load) | accept;
    if (accept) begin
      hold_data_next = bus.tx_data;
    end
  end

  assign bus.MISO      = CPHA ? miso_reg
                              : ((state_reg == ACTIVE) & shifter_reg[WIDTH-1]);
  assign bus.tx_ready  = ~hold_full_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = (state_reg == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// One spi_slave per SPI mode (0..3), each on its own interface. A behavioural
// SPI master task drives the selected instance; expected received bytes are
// queued as they are transmitted and matched against rx_valid events.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave;

  logic CLK;
  logic reset;

  logic       sclk_d   [4];
  logic       cs_d     [4];
  logic       mosi_d   [4];
  logic [7:0] txd_d    [4];
  logic       txv_d    [4];

  logic       miso_w   [4];
  logic       ready_w  [4];
  logic [7:0] rxd_w    [4];
  logic       rxv_w    [4];
  logic       und_w    [4];
  logic       ferr_w   [4];
  logic       busy_w   [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave_if u_if ();
      assign u_if.SCLK     = sclk_d[gi];
      assign u_if.CS       = cs_d[gi];
      assign u_if.MOSI     = mosi_d[gi];
      assign u_if.tx_data  = txd_d[gi];
      assign u_if.tx_valid = txv_d[gi];
      assign miso_w[gi]    = u_if.MISO;
      assign ready_w[gi]   = u_if.tx_ready;
      assign rxd_w[gi]     = u_if.rx_data;
      assign rxv_w[gi]     = u_if.rx_valid;
      assign und_w[gi]     = u_if.underrun;
      assign ferr_w[gi]    = u_if.frame_err;
      assign busy_w[gi]    = u_if.busy;
      spi_slave #(.MODE(2'(gi)), .WIDTH(8)) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (u_if)
      );
    end
  endgenerate

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor of the instance under test.
  int         cur = 0;
  int         obs_wr = 0;
  logic [7:0] obs_data [32];
  int         obs_cyc  [32];
  int         rxv_cnt = 0;
  int         und_cnt = 0;
  int         ferr_cnt = 0;

  always @(negedge CLK) begin
    if (rxv_w[cur] === 1'b1) begin
      if (obs_wr < 32) begin
        obs_data[obs_wr] <= rxd_w[cur];
        obs_cyc[obs_wr]  <= cyc;
        obs_wr           <= obs_wr + 1;
      end
      rxv_cnt <= rxv_cnt + 1;
    end
    if (und_w[cur] === 1'b1)  und_cnt  <= und_cnt + 1;
    if (ferr_w[cur] === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  int         checks = 0;
  int         errors = 0;
  int         obs_rd = 0;
  int         last_samp = 0;
  logic [7:0] exp_q [$];
  localparam int HALF = 6;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cs_low(input int m);
    cs_d[m] = 1'b0;
    tick(8);
  endtask

  task automatic cs_high(input int m);
    cs_d[m] = 1'b1;
    tick(8);
  endtask

  // Master side of one byte (or a partial byte of nbits). MISO is captured
  // on the master's sample edge; full bytes are queued as expected rx data.
  task automatic spi_xfer(input int m, input logic [7:0] mo, input int nbits,
                          output logic [7:0] mi);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi = 8'h00;
    if (nbits == 8) exp_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_d[m] = mo[7-i];
        tick(HALF);
        mi[7-i] = miso_w[m];
        sclk_d[m] = ~cpol;
        if (i == nbits - 1) last_samp = cyc;
        tick(HALF);
        sclk_d[m] = cpol;
      end else begin
        sclk_d[m] = ~cpol;
        mosi_d[m] = mo[7-i];
        tick(HALF);
        mi[7-i] = miso_w[m];
        sclk_d[m] = cpol;
        if (i == nbits - 1) last_samp = cyc;
        tick(HALF);
      end
    end
    tick(HALF);
  endtask

  // Bounded wait for the next observed byte, paired with the oldest expected.
  task automatic sb_pop(output bit have, output logic [7:0] got,
                        output logic [7:0] want, output int at_cyc);
    have = 1'b0; got = 8'h00; want = 8'h00; at_cyc = 0;
    for (int k = 0; k < 60 && obs_rd >= obs_wr; k++) tick(1);
    if (obs_rd < obs_wr && exp_q.size() > 0) begin
      have   = 1'b1;
      got    = obs_data[obs_rd];
      at_cyc = obs_cyc[obs_rd];
      obs_rd++;
      want   = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    reset = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      got = {miso_w[i], rxd_w[i], rxv_w[i], und_w[i], ferr_w[i], busy_w[i], ready_w[i]};
      checks++;
      if (got !== 15'b0_00000000_0000_1) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got=%h want=%h", i, got, 15'b0_00000000_0000_1);
      end
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_mode3_basic();
    logic [7:0] mi, got, want;
    bit have;
    int at, r0, u0, f0;
    cur = 3; tick(1);
    r0 = rxv_cnt; u0 = und_cnt; f0 = ferr_cnt;
    txd_d[3] = 8'hA5; txv_d[3] = 1'b1;
    checks++;
    if (ready_w[3] !== 1'b1) begin errors++; $display("FAIL t1_ready_before got=%b want=1", ready_w[3]); end
    tick(1);
    txv_d[3] = 1'b0;
    checks++;
    if (ready_w[3] !== 1'b0) begin errors++; $display("FAIL t1_ready_drop got=%b want=0", ready_w[3]); end
    cs_low(3);
    checks++;
    if (busy_w[3] !== 1'b1 || ready_w[3] !== 1'b1) begin
      errors++; $display("FAIL t1_cs_fall busy=%b ready=%b want 1 1", busy_w[3], ready_w[3]);
    end
    spi_xfer(3, 8'h3C, 8, mi);
    checks++;
    if (mi !== 8'hA5) begin errors++; $display("FAIL t1_miso got=%02h want=a5", mi); end
    sb_pop(have, got, want, at);
    checks++;
    if (!have || got !== want) begin errors++; $display("FAIL t1_rx got=%02h want=%02h have=%0d", got, want, have); end
    checks++;
    if (at - last_samp != 3) begin errors++; $display("FAIL t1_latency got=%0d want=3", at - last_samp); end
    cs_high(3);
    checks++;
    if (rxv_cnt - r0 != 1 || und_cnt - u0 != 1 || ferr_cnt - f0 != 0 || busy_w[3] !== 1'b0) begin
      errors++;
      $display("FAIL t1_pulses rxv=%0d und=%0d ferr=%0d busy=%b want 1 1 0 0",
               rxv_cnt - r0, und_cnt - u0, ferr_cnt - f0, busy_w[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2, got, want;
    bit have;
    int at, r0, u0, f0;
    cur = 0; tick(1);
    r0 = rxv_cnt; u0 = und_cnt; f0 = ferr_cnt;
    txd_d[0] = 8'h81; txv_d[0] = 1'b1; tick(1); txv_d[0] = 1'b0;
    cs_low(0);
    txd_d[0] = 8'h7E; txv_d[0] = 1'b1; tick(1); txv_d[0] = 1'b0;
    spi_xfer(0, 8'hF0, 8, mi1);
    txd_d[0] = 8'h5A; txv_d[0] = 1'b1; tick(1); txv_d[0] = 1'b0;
    spi_xfer(0, 8'h0F, 8, mi2);
    checks++;
    if (mi1 !== 8'h81) begin errors++; $display("FAIL t2_miso1 got=%02h want=81", mi1); end
    checks++;
    if (mi2 !== 8'h7E) begin errors++; $display("FAIL t2_miso2 got=%02h want=7e", mi2); end
    for (int b = 0; b < 2; b++) begin
      sb_pop(have, got, want, at);
      checks++;
      if (!have || got !== want) begin errors++; $display("FAIL t2_rx%0d got=%02h want=%02h have=%0d", b, got, want, have); end
    end
    cs_high(0);
    checks++;
    if (rxv_cnt - r0 != 2 || und_cnt - u0 != 0 || ferr_cnt - f0 != 0) begin
      errors++;
      $display("FAIL t2_pulses rxv=%0d und=%0d ferr=%0d want 2 0 0", rxv_cnt - r0, und_cnt - u0, ferr_cnt - f0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi, got, want;
    bit have;
    int at, u0;
    cur = 1; tick(1);
    u0 = und_cnt;
    cs_low(1);
    checks++;
    if (und_cnt - u0 != 1) begin errors++; $display("FAIL t3_underrun got=%0d want=1", und_cnt - u0); end
    spi_xfer(1, 8'h55, 8, mi);
    checks++;
    if (mi !== 8'h00) begin errors++; $display("FAIL t3_miso got=%02h want=00", mi); end
    sb_pop(have, got, want, at);
    checks++;
    if (!have || got !== want) begin errors++; $display("FAIL t3_rx got=%02h want=%02h have=%0d", got, want, have); end
    cs_high(1);
    checks++;
    if (rxd_w[1] !== 8'h55) begin errors++; $display("FAIL t3_rx_data got=%02h want=55", rxd_w[1]); end
  endtask

  task automatic test_frame_err();
    logic [7:0] mi, got, want;
    bit have;
    int at, r0, f0;
    cur = 3; tick(1);
    r0 = rxv_cnt; f0 = ferr_cnt;
    cs_low(3);
    spi_xfer(3, 8'hFF, 5, mi);
    cs_high(3);
    checks++;
    if (ferr_cnt - f0 != 1 || rxv_cnt - r0 != 0) begin
      errors++; $display("FAIL t4_abort ferr=%0d rxv=%0d want 1 0", ferr_cnt - f0, rxv_cnt - r0);
    end
    checks++;
    if (rxd_w[3] !== 8'h3C) begin errors++; $display("FAIL t4_rx_hold got=%02h want=3c", rxd_w[3]); end
    cs_low(3);
    spi_xfer(3, 8'h12, 8, mi);
    sb_pop(have, got, want, at);
    checks++;
    if (!have || got !== want) begin errors++; $display("FAIL t4_rx got=%02h want=%02h have=%0d", got, want, have); end
    cs_high(3);
    checks++;
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL t4_ferr_total got=%0d want=1", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] mi, got, want;
    logic [14:0] outs;
    bit have;
    int at, r0, f0;
    cur = 0; tick(1);
    cs_low(0);
    spi_xfer(0, 8'hE0, 3, mi);
    r0 = rxv_cnt; f0 = ferr_cnt;
    reset = 1'b1;
    cs_d[0] = 1'b1; sclk_d[0] = 1'b0; mosi_d[0] = 1'b0;
    tick(1);
    outs = {miso_w[0], rxd_w[0], rxv_w[0], und_w[0], ferr_w[0], busy_w[0], ready_w[0]};
    checks++;
    if (outs !== 15'b0_00000000_0000_1) begin
      errors++; $display("FAIL t5_reset_outputs got=%h want=%h", outs, 15'b0_00000000_0000_1);
    end
    tick(3);
    reset = 1'b0;
    tick(6);
    checks++;
    if (ferr_cnt - f0 != 0 || rxv_cnt - r0 != 0) begin
      errors++; $display("FAIL t5_no_pulse ferr=%0d rxv=%0d want 0 0", ferr_cnt - f0, rxv_cnt - r0);
    end
    cs_low(0);
    spi_xfer(0, 8'hC3, 8, mi);
    sb_pop(have, got, want, at);
    checks++;
    if (!have || got !== want) begin errors++; $display("FAIL t5_rx got=%02h want=%02h have=%0d", got, want, have); end
    cs_high(0);
  endtask

  task automatic test_idle_hold();
    logic [7:0] mi, got, want;
    bit have;
    int at, r0;
    cur = 2; tick(1);
    txd_d[2] = 8'h99; txv_d[2] = 1'b1;
    tick(1);
    checks++;
    if (ready_w[2] !== 1'b0) begin errors++; $display("FAIL t6_ready_drop got=%b want=0", ready_w[2]); end
    txv_d[2] = 1'b0;
    tick(10);
    checks++;
    if (ready_w[2] !== 1'b0) begin errors++; $display("FAIL t6_ready_low got=%b want=0", ready_w[2]); end
    cs_low(2);
    checks++;
    if (ready_w[2] !== 1'b1) begin errors++; $display("FAIL t6_ready_back got=%b want=1", ready_w[2]); end
    spi_xfer(2, 8'h6B, 8, mi);
    checks++;
    if (mi !== 8'h99) begin errors++; $display("FAIL t6_miso got=%02h want=99", mi); end
    sb_pop(have, got, want, at);
    checks++;
    if (!have || got !== want) begin errors++; $display("FAIL t6_rx got=%02h want=%02h have=%0d", got, want, have); end
    cs_high(2);
    r0 = rxv_cnt;
    for (int k = 0; k < 16; k++) begin
      mosi_d[2] = 1'($urandom_range(0, 1));
      sclk_d[2] = ~sclk_d[2];
      tick(HALF);
    end
    tick(6);
    checks++;
    if (rxv_cnt - r0 != 0 || busy_w[2] !== 1'b0) begin
      errors++; $display("FAIL t6_cs_high_sclk rxv=%0d busy=%b want 0 0", rxv_cnt - r0, busy_w[2]);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_d[i] = (i >= 2);
      cs_d[i]   = 1'b1;
      mosi_d[i] = 1'b0;
      txd_d[i]  = 8'h00;
      txv_d[i]  = 1'b0;
    end
    test_reset();
    test_mode3_basic();
    test_back_to_back();
    test_underrun();
    test_frame_err();
    test_reset_mid_byte();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout cycles=%0d limit=200000", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the same 8-bit, MSB-first SPI link our bus master drives.
- Sits at the peripheral end of the link: samples MOSI, drives MISO, and frames bytes with CS (active-low).
- All SPI pins are treated as asynchronous to CLK and oversampled.
- Presents received bytes as a one-cycle valid pulse and accepts transmit bytes through a valid/ready holding register.

Parameters:
- MODE, 2'd3, {CPOL, CPHA}; must match the master's mode.
- WIDTH, 8, frame width in bits; only 8 is supported.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock from the master, asynchronous.
- CS  input  1  chip select, active-low, asynchronous.
- MOSI  input  1  master-out serial data, asynchronous.
- MISO  output  1  slave-out serial data.
- tx_data  input  8  next byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register is empty; a byte can be accepted.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-CLK pulse when rx_data updates.
- underrun  output  1  one-CLK pulse: shifter was loaded while the holding register was empty.
- frame_err  output  1  one-CLK pulse: CS deasserted mid-byte.
- busy  output  1  high while the synchronized CS is low.

Behaviour:
- Reset (synchronous, active-high; clock CLK) values:
  - MISO=0, rx_data=0, rx_valid=0, underrun=0, frame_err=0, busy=0, tx_ready=1.
  - Shifter=0, bit counter=0, synchronizers set to idle (SCLK=CPOL, CS=1).
  - Reset mid-frame aborts the frame with no pulses.
- Synchronization:
  - SCLK, CS and MOSI each pass through 2 flops, plus a 3rd flop for edge detect.
  - The action for a pin edge takes effect on the 3rd CLK rising edge after the pin change.
  - MOSI is sampled from its synchronized copy.
- Timing requirement: SCLK high and low phases each ≥4 CLK periods. MOSI must be stable ≥3 CLK periods around the sample edge.
- Edge roles:
  - Leading edge = transition away from CPOL.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- State machine:
  - IDLE: CS_sync high, MISO=0. On CS_sync falling: load shifter, clear counter, go to ACTIVE.
  - ACTIVE: on CS_sync rising, go back to IDLE.
- Shifter load (at CS fall and at byte completion):
  - Holding register full: shifter←holding, holding marked empty (tx_ready←1).
  - Holding register empty: shifter←8'h00, underrun pulses.
- MISO drive:
  - CPHA=0: MISO=shifter[7] continuously in ACTIVE. Shift edge: shifter←{shifter[6:0],0}.
  - CPHA=1: shift edge does MISO←shifter[7] and shifter←{shifter[6:0],0}. MISO holds between shift edges.
- Receive:
  - Sample edge: rx_shift←{rx_shift[6:0],MOSI_sync}, counter+1 (3-bit, wraps 7→0).
  - On the 8th sample: rx_data←completed byte and rx_valid=1 for exactly one CLK.
  - The shifter reloads in that same cycle, so back-to-back bytes within one CS are supported.
  - No backpressure: a new byte overwrites rx_data.
- Holding register:
  - Accepts a byte when tx_valid & tx_ready; tx_ready drops the next cycle.
  - If an accept and a shifter load occur in the same cycle, the shifter takes the old holding content and the new byte enters holding (tx_ready stays 0).
  - If holding is empty at load, the incoming byte goes to holding and underrun still pulses.
- CS rises with counter≠0: frame_err pulses, partial byte is discarded, no rx_valid. CS rises with counter=0: no pulse.
- CS glitch shorter than 2 CLK may be missed; this is acceptable.
- SCLK edges while CS_sync is high are ignored.

Test Plan:
1. Mode 3, preload tx_data=8'hA5, CS low, master sends 8'h3C → rx_data=8'h3C, single rx_valid pulse 3 CLK after the 8th rising SCLK; MISO bit stream seen by the master = 8'hA5.
2. Mode 0, preload 8'h81, two bytes 8'hF0 then 8'h0F in one CS with 8'h7E loaded after the first load → rx_valid twice (F0, 0F); MISO sends 81 then 7E; underrun never pulses.
3. No preload, mode 1, master sends 8'h55 → MISO all zeros, underrun pulses once at CS fall, rx_data=8'h55.
4. CS deasserted after 5 SCLK cycles of 8'hFF → frame_err pulses once, rx_valid stays 0, rx_data unchanged, next full frame 8'h12 received correctly.
5. Reset asserted mid-byte (after 3 bits) → all outputs reach reset values next cycle; tx_ready=1; subsequent frame 8'hC3 received correctly.
6. tx_valid held high with 8'h99 while idle → tx_ready drops after 1 cycle, stays low until CS fall, then returns to 1; SCLK toggling with CS high → no rx_valid.
